pwm_cfg_ctrl: RTL and testbench
===============================

# pwm_cfg_ctrl

Configuration sequencer for the PWM counter. Accepts period/duty/mode/enable updates from the register interface over a valid/ready handshake and holds them in shadow registers. Commits them to the counter's control inputs only at a counter period boundary, so the running waveform never sees a torn update. Issues a one-cycle counter clear when the counting mode changes and guards the up-down zero-period hazard.

## Interface
- WIDTH, 64, width of period, duty and counter value
- clk  in  1  counter clock (slow_clk domain)
- ctrl_rst  in  1  asynchronous, active-high reset
- cfg_valid  in  1  update request valid
- cfg_ready  out  1  controller can accept an update
- cfg_period  in  WIDTH  requested period
- cfg_duty  in  WIDTH  requested duty compare value
- cfg_mode  in  1  requested mode: 0 up, 1 up-down
- cfg_en  in  1  requested PWM enable
- cnt_val  in  WIDTH  current counter value
- pwm_en  out  1  drives counter PWM_EN
- cnt_mode  out  1  drives counter mode
- cnt_period  out  WIDTH  drives counter period
- cnt_duty  out  WIDTH  active duty to the compare stage
- cnt_clr  out  1  registered one-cycle clear, OR'ed into counter cnt_rst
- cfg_done  out  1  one-cycle pulse: the update is now active
- cfg_err  out  1  one-cycle pulse with cfg_done: the period was clamped

## Operation
- Reset: state IDLE; pwm_en, cnt_mode, cnt_clr, cfg_done and cfg_err = 0; cnt_period and cnt_duty = 0; shadow registers = 0; cfg_ready = 1.
- cfg_ready = 1 in IDLE and RUN, 0 in PEND and CLR. Accept occurs on the edge where cfg_valid & cfg_ready; the cfg_* inputs are latched into the shadow registers. Only one update is outstanding.
- Boundary, evaluated from the pre-edge cnt_val and the active registers:
  - Mode 0: boundary when cnt_val >= cnt_period, i.e. the wrap cycle.
  - Mode 1: boundary when cnt_val == 0, i.e. the bottom of the down-slope or the start.
- States:
  - IDLE: pwm_en = 0. On accept, commit on the next edge without waiting for a boundary, then RUN if cfg_en = 1, else stay in IDLE.
  - RUN: pwm_en = 1. On accept go to PEND.
  - PEND: at the first boundary edge:
    - shadow cfg_en = 0: commit and go to IDLE.
    - shadow mode differs from cnt_mode: go to CLR.
    - otherwise commit and go to RUN.
  - CLR: cnt_clr = 1 for exactly one cycle, and the active registers are committed on entry. Next edge: RUN with cnt_clr = 0.
- Commit: cnt_period, cnt_duty, cnt_mode and pwm_en load from the shadow registers. cfg_done pulses in the cycle after the commit edge; from CLR it pulses in the cycle after leaving CLR.
- Clamp: committing mode 1 with period 0 loads cnt_period = 1 and pulses cfg_err with cfg_done. Mode 0 with period 0 is legal: the output is constant 0 and no cfg_err is raised.
- Duty is not clamped; duty > period passes through unchanged.
- A reset mid-operation drops any pending update with no cfg_done.

## Timing
- Accept edge E0 in IDLE: commit at E1, pwm_en high after E1, cfg_done high in the cycle E1..E2.
- Accept in RUN: commit no earlier than E1. The worst case is one full counter period (mode 0) or two periods (mode 1).
- A boundary on the same edge as accept is ignored; the earliest commit is at the next boundary.
- Commit in mode 0 coincides with the counter's wrap edge, so the counter shows 0 with the new period on the next cycle.
- All outputs are registered; no combinational path runs from cfg_* to the cnt_* outputs. cfg_ready is decoded directly from the state register.

## Configuration
- PWM_CFG_FORCE_EN defined: adds input port cfg_force (1 bit), sampled with an accepted request. If it is 1, the update bypasses boundary waiting: the controller goes to CLR on the next edge, which pulses cnt_clr and commits, regardless of the mode change. From IDLE, cfg_force has no extra effect.
- Macro undefined: no cfg_force port; every update in RUN waits for a boundary.

## Test plan
- Reset, then accept {period=9, duty=4, mode=0, en=1} in IDLE -> pwm_en=1 and cnt_period=9 one edge after accept; cfg_done pulses once; cnt_clr stays 0.
- In RUN with period 9, accept period=5 at cnt_val=3 -> cnt_period stays 9 until the edge with cnt_val=9, then becomes 5; the counter then shows 0; cfg_ready is low during the wait.
- In RUN mode 0, accept mode=1, period=6 -> at the boundary cnt_clr is high for exactly 1 cycle, cnt_mode=1, and cfg_done follows the next cycle.
- Accept mode=1, period=0 -> cnt_period=1, cfg_err and cfg_done pulse together.
- Accept en=0 in RUN -> pwm_en drops at the boundary edge and the state returns to IDLE. Then assert ctrl_rst while a request is in PEND -> all outputs return to reset values and no cfg_done is produced.
- With PWM_CFG_FORCE_EN defined, accept with cfg_force=1 at cnt_val=2 of period 9 -> cnt_clr high the next cycle, new values committed without reaching 9.

Source files
------------

// File: rtl/pwm_cfg_ctrl.sv
// pwm_cfg_ctrl: configuration sequencer for the PWM counter.
// Update requests are captured in shadow registers over a valid/ready
// handshake and copied into the counter controls only at a period boundary,
// so a running waveform never mixes old and new settings. A mode change
// passes through CLR, which issues a one-cycle counter clear.
// Optional build macro: PWM_CFG_FORCE_EN adds the cfg_force input, which lets
// an update from RUN skip the boundary wait and go straight through CLR.
//
// state | meaning
// IDLE  | PWM disabled, ready for an update (committed on the next edge)
// RUN   | PWM running with the active settings, ready for an update
// PEND  | update held in shadow, waiting for a period boundary
// CLR   | settings committed, counter clear asserted for one cycle

module pwm_cfg_ctrl #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             ctrl_rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_period,
  input  logic [WIDTH-1:0] cfg_duty,
  input  logic             cfg_mode,
  input  logic             cfg_en,
`ifdef PWM_CFG_FORCE_EN
  input  logic             cfg_force,
`endif
  input  logic [WIDTH-1:0] cnt_val,
  output logic             pwm_en,
  output logic             cnt_mode,
  output logic [WIDTH-1:0] cnt_period,
  output logic [WIDTH-1:0] cnt_duty,
  output logic             cnt_clr,
  output logic             cfg_done,
  output logic             cfg_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2,
    CLR  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] sh_period;
  logic [WIDTH-1:0] sh_duty;
  logic             sh_mode;
  logic             sh_en;
  logic             sh_imm;
`ifdef PWM_CFG_FORCE_EN
  logic             sh_force;
`endif

  logic             accept;
  logic             boundary;
  logic             clamp;
  logic [WIDTH-1:0] period_commit;
  logic             do_commit;
  logic             done_nxt;

  assign cfg_ready = (state == IDLE) || (state == RUN);
  assign accept    = cfg_valid && cfg_ready;

  // Boundary uses the active mode/period and the counter value before the edge.
  assign boundary = cnt_mode ? (cnt_val == '0) : (cnt_val >= cnt_period);

  // Up-down counting cannot run with a zero period, so it is forced to 1.
  assign clamp         = sh_mode && (sh_period == '0);
  assign period_commit = clamp ? WIDTH'(1) : sh_period;

  // State register.
  always_ff @(posedge clk or posedge ctrl_rst) begin
    if (ctrl_rst) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state plus commit and completion decisions.
  always_comb begin
    state_nxt = state;
    do_commit = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = PEND;
      end
      RUN: begin
        if (accept) state_nxt = PEND;
      end
      PEND: begin
        if (sh_imm) begin
          // Request came from IDLE: nothing is running, so no boundary wait.
          do_commit = 1'b1;
          done_nxt  = 1'b1;
          state_nxt = sh_en ? RUN : IDLE;
        end
`ifdef PWM_CFG_FORCE_EN
        else if (sh_force) begin
          do_commit = 1'b1;
          state_nxt = CLR;
        end
`endif
        else if (boundary) begin
          do_commit = 1'b1;
          if (!sh_en) begin
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end else if (sh_mode != cnt_mode) begin
            state_nxt = CLR;
          end else begin
            done_nxt  = 1'b1;
            state_nxt = RUN;
          end
        end
      end
      CLR: begin
        // A forced update may carry en=0; leave the counter disabled then.
        done_nxt  = 1'b1;
        state_nxt = pwm_en ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shadow capture, active-register commit and registered status pulses.
  always_ff @(posedge clk or posedge ctrl_rst) begin
    if (ctrl_rst) begin
      sh_period  <= '0;
      sh_duty    <= '0;
      sh_mode    <= 1'b0;
      sh_en      <= 1'b0;
      sh_imm     <= 1'b0;
`ifdef PWM_CFG_FORCE_EN
      sh_force   <= 1'b0;
`endif
      cnt_period <= '0;
      cnt_duty   <= '0;
      cnt_mode   <= 1'b0;
      pwm_en     <= 1'b0;
      cnt_clr    <= 1'b0;
      cfg_done   <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      if (accept) begin
        sh_period <= cfg_period;
        sh_duty   <= cfg_duty;
        sh_mode   <= cfg_mode;
        sh_en     <= cfg_en;
        sh_imm    <= (state == IDLE);
`ifdef PWM_CFG_FORCE_EN
        sh_force  <= cfg_force;
`endif
      end
      if (do_commit) begin
        cnt_period <= period_commit;
        cnt_duty   <= sh_duty;
        cnt_mode   <= sh_mode;
        pwm_en     <= sh_en;
      end
      // Shadow is stable through CLR, so the clamp flag is still valid here.
      cnt_clr  <= (state_nxt == CLR);
      cfg_done <= done_nxt;
      cfg_err  <= done_nxt && clamp;
    end
  end

endmodule

// File: tb/tb_pwm_cfg_ctrl.sv
// Directed bench for pwm_cfg_ctrl: cnt_val is driven by hand to place the
// period boundaries exactly; expected values are written out per step.

module tb_pwm_cfg_ctrl;

  localparam int WIDTH = 64;

  logic             clk;
  logic             ctrl_rst;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [WIDTH-1:0] cfg_period;
  logic [WIDTH-1:0] cfg_duty;
  logic             cfg_mode;
  logic             cfg_en;
  logic [WIDTH-1:0] cnt_val;
  logic             pwm_en;
  logic             cnt_mode;
  logic [WIDTH-1:0] cnt_period;
  logic [WIDTH-1:0] cnt_duty;
  logic             cnt_clr;
  logic             cfg_done;
  logic             cfg_err;

  int n_vec;
  int n_err;

  pwm_cfg_ctrl #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .ctrl_rst   (ctrl_rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_period (cfg_period),
    .cfg_duty   (cfg_duty),
    .cfg_mode   (cfg_mode),
    .cfg_en     (cfg_en),
    .cnt_val    (cnt_val),
    .pwm_en     (pwm_en),
    .cnt_mode   (cnt_mode),
    .cnt_period (cnt_period),
    .cnt_duty   (cnt_duty),
    .cnt_clr    (cnt_clr),
    .cfg_done   (cfg_done),
    .cfg_err    (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] d,
                     input logic m, input logic e);
    cfg_valid  = 1'b1;
    cfg_period = p;
    cfg_duty   = d;
    cfg_mode   = m;
    cfg_en     = e;
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    ctrl_rst   = 1'b1;
    cfg_valid  = 1'b0;
    cfg_period = '0;
    cfg_duty   = '0;
    cfg_mode   = 1'b0;
    cfg_en     = 1'b0;
    cnt_val    = '0;

    // Reset values
    step(); step();
    check("rst_pwm_en", pwm_en, 0);
    check("rst_cnt_period", cnt_period, 0);
    check("rst_cnt_duty", cnt_duty, 0);
    check("rst_cnt_mode", cnt_mode, 0);
    check("rst_cnt_clr", cnt_clr, 0);
    check("rst_cfg_done", cfg_done, 0);
    check("rst_cfg_ready", cfg_ready, 1);
    ctrl_rst = 1'b0;
    step();

    // First update from IDLE: commits one edge after accept
    req(9, 4, 1'b0, 1'b1);
    step();
    cfg_valid = 1'b0;
    check("t1_ready_pend", cfg_ready, 0);
    check("t1_pwm_en_pre", pwm_en, 0);
    check("t1_done_pre", cfg_done, 0);
    step();
    check("t1_pwm_en", pwm_en, 1);
    check("t1_period", cnt_period, 9);
    check("t1_duty", cnt_duty, 4);
    check("t1_done", cfg_done, 1);
    check("t1_clr", cnt_clr, 0);
    check("t1_ready_run", cfg_ready, 1);
    step();
    check("t1_done_once", cfg_done, 0);

    // RUN, mode 0: period 9 -> 5 accepted at cnt_val=3, commits on wrap
    cnt_val = 3;
    req(5, 2, 1'b0, 1'b1);
    step();
    cfg_valid = 1'b0;
    check("t2_ready_wait", cfg_ready, 0);
    for (int v = 4; v <= 8; v++) begin
      cnt_val = v;
      step();
      check("t2_period_hold", cnt_period, 9);
      check("t2_ready_wait", cfg_ready, 0);
      check("t2_no_done", cfg_done, 0);
    end
    cnt_val = 9;
    step();
    check("t2_period_new", cnt_period, 5);
    check("t2_duty_new", cnt_duty, 2);
    check("t2_done", cfg_done, 1);
    check("t2_ready", cfg_ready, 1);
    cnt_val = 0;
    step();
    check("t2_done_once", cfg_done, 0);

    // Mode change 0 -> 1 passes through CLR
    cnt_val = 1;
    req(6, 3, 1'b1, 1'b1);
    step();
    cfg_valid = 1'b0;
    cnt_val = 2;
    step();
    check("t3_clr_early", cnt_clr, 0);
    check("t3_mode_hold", cnt_mode, 0);
    cnt_val = 5;
    step();
    check("t3_clr", cnt_clr, 1);
    check("t3_mode", cnt_mode, 1);
    check("t3_period", cnt_period, 6);
    check("t3_done_in_clr", cfg_done, 0);
    check("t3_ready_clr", cfg_ready, 0);
    cnt_val = 0;
    step();
    check("t3_clr_one", cnt_clr, 0);
    check("t3_done", cfg_done, 1);
    check("t3_err", cfg_err, 0);
    check("t3_ready_run", cfg_ready, 1);
    step();
    check("t3_done_once", cfg_done, 0);

    // Mode 1, period 0 clamps to 1; boundary on accept edge is ignored
    cnt_val = 0;
    req(0, 0, 1'b1, 1'b1);
    step();
    cfg_valid = 1'b0;
    cnt_val = 1;
    step();
    check("t4_period_hold", cnt_period, 6);
    check("t4_no_done", cfg_done, 0);
    cnt_val = 0;
    step();
    check("t4_period_clamp", cnt_period, 1);
    check("t4_err", cfg_err, 1);
    check("t4_done", cfg_done, 1);
    check("t4_clr", cnt_clr, 0);
    step();
    check("t4_err_once", cfg_err, 0);

    // en=0 in RUN: pwm_en drops at the boundary, back to IDLE
    cnt_val = 1;
    req(4, 2, 1'b1, 1'b0);
    step();
    cfg_valid = 1'b0;
    cnt_val = 0;
    step();
    check("t5_pwm_off", pwm_en, 0);
    check("t5_done", cfg_done, 1);
    check("t5_period", cnt_period, 4);
    check("t5_ready", cfg_ready, 1);

    // From IDLE: commits without boundary, no clear despite mode change,
    // duty above period passes through
    cnt_val = 3;
    req(7, 12, 1'b0, 1'b1);
    step();
    cfg_valid = 1'b0;
    step();
    check("t6_pwm_en", pwm_en, 1);
    check("t6_period", cnt_period, 7);
    check("t6_duty", cnt_duty, 12);
    check("t6_mode", cnt_mode, 0);
    check("t6_clr", cnt_clr, 0);
    check("t6_done", cfg_done, 1);

    // Reset while an update is pending
    cnt_val = 2;
    req(3, 1, 1'b0, 1'b1);
    step();
    cfg_valid = 1'b0;
    check("t7_pend", cfg_ready, 0);
    ctrl_rst = 1'b1;
    #1;
    check("t7_rst_pwm_en", pwm_en, 0);
    check("t7_rst_period", cnt_period, 0);
    check("t7_rst_duty", cnt_duty, 0);
    check("t7_rst_ready", cfg_ready, 1);
    check("t7_rst_done", cfg_done, 0);
    step();
    ctrl_rst = 1'b0;
    cnt_val = 3;
    step();
    check("t7_no_done", cfg_done, 0);
    check("t7_period_idle", cnt_period, 0);
    step();
    check("t7_no_done2", cfg_done, 0);
    check("t7_pwm_idle", pwm_en, 0);

    // Mode 0 with period 0 is legal, no error pulse
    req(7, 5, 1'b0, 1'b1);
    step();
    cfg_valid = 1'b0;
    step();
    check("t8_period_init", cnt_period, 7);
    cnt_val = 2;
    req(0, 0, 1'b0, 1'b1);
    step();
    cfg_valid = 1'b0;
    cnt_val = 7;
    step();
    check("t8_period_zero", cnt_period, 0);
    check("t8_done", cfg_done, 1);
    check("t8_no_err", cfg_err, 0);
    check("t8_pwm_en", pwm_en, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
